// File: rtl/result_unloader_if.sv
// Memory read port and transmit byte stream of the result unloader.
// master: the unloader side; slave: the memory/transmitter side.
interface result_unloader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_rd_en, mem_addr, tx_data, tx_valid,
        input  mem_data, tx_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_data, tx_valid,
        output mem_data, tx_ready
    );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: reads count words from data memory starting at base_addr
// (wrapping modulo 2^ADDR_W) and streams each word out high byte first over
// a valid/ready byte interface. Reports busy and a one-cycle done pulse.
// Optional macro UNLOAD_HEADER_EN: prefix a non-empty dump with 0xA5, count.
module result_unloader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   count,
    result_unloader_if.master   bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND_HI,
        SEND_LO,
`ifdef UNLOAD_HEADER_EN
        HEADER,
`endif
        FINISH
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [ADDR_W-1:0] count_q, count_n;
    logic [ADDR_W-1:0] index_q, index_n;
    logic [DATA_W-1:0] word_q, word_n;
    logic [1:0]        wait_q, wait_n;
`ifdef UNLOAD_HEADER_EN
    logic              hdr_q, hdr_n;
`endif

    logic              mem_rd_en_q, mem_rd_en_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [7:0]        tx_data_q, tx_data_n;
    logic              tx_valid_q, tx_valid_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // State, datapath and registered outputs; async reset clears everything
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            index_q     <= '0;
            word_q      <= '0;
            wait_q      <= '0;
`ifdef UNLOAD_HEADER_EN
            hdr_q       <= 1'b0;
`endif
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            count_q     <= count_n;
            index_q     <= index_n;
            word_q      <= word_n;
            wait_q      <= wait_n;
`ifdef UNLOAD_HEADER_EN
            hdr_q       <= hdr_n;
`endif
            mem_rd_en_q <= mem_rd_en_n;
            mem_addr_q  <= mem_addr_n;
            tx_data_q   <= tx_data_n;
            tx_valid_q  <= tx_valid_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
        end
    end

    // Next state; outputs are decoded from the next state so they are registered
    always_comb begin
        state_n   = state;
        base_n    = base_q;
        count_n   = count_q;
        index_n   = index_q;
        word_n    = word_q;
        wait_n    = wait_q;
        tx_data_n = tx_data_q;
`ifdef UNLOAD_HEADER_EN
        hdr_n     = hdr_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    base_n  = base_addr;
                    count_n = count;
                    index_n = '0;
                    if (count == '0) begin
                        state_n = FINISH;
                    end else begin
`ifdef UNLOAD_HEADER_EN
                        hdr_n     = 1'b0;
                        tx_data_n = 8'hA5;
                        state_n   = HEADER;
`else
                        state_n   = ISSUE;
`endif
                    end
                end
            end
`ifdef UNLOAD_HEADER_EN
            HEADER: begin
                if (bus.tx_ready) begin
                    if (!hdr_q) begin
                        hdr_n     = 1'b1;
                        tx_data_n = 8'(count_q);
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
`endif
            ISSUE: begin
                wait_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // Byte registers load straight from memory so SEND_HI presents data immediately
                if (wait_q == LAT_LAST) begin
                    word_n    = bus.mem_data;
                    tx_data_n = bus.mem_data[15:8];
                    state_n   = SEND_HI;
                end else begin
                    wait_n = wait_q + 2'd1;
                end
            end
            SEND_HI: begin
                if (bus.tx_ready) begin
                    tx_data_n = word_q[7:0];
                    state_n   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (bus.tx_ready) begin
                    index_n = index_q + ADDR_W'(1);
                    state_n = (index_n == count_q) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        mem_rd_en_n = (state_n == ISSUE);
        mem_addr_n  = (state_n == ISSUE) ? (base_n + index_n) : mem_addr_q;
        tx_valid_n  = (state_n == SEND_HI) || (state_n == SEND_LO)
`ifdef UNLOAD_HEADER_EN
                      || (state_n == HEADER)
`endif
                      ;
        busy_n      = (state_n != IDLE) && (state_n != FINISH);
        done_n      = (state_n == FINISH);
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Downstream of the processing core.
- When the core asserts its end-of-process signal, this block takes over the data-memory read port and reads the result matrix from data memory word by word.
- It streams each 16-bit word out as two bytes over a valid/ready byte interface that feeds the UART transmitter.
- It reports busy/done to the top level so the host knows the result dump is complete.

Parameters:
- ADDR_W, 8, data-memory address width
- DATA_W, 16, data-memory word width (fixed to 2 bytes per word)
- MEM_LATENCY, 1, cycles from mem_addr/mem_rd_en to valid mem_data (1..3)

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse from the core's end-of-process output
- base_addr  in  ADDR_W  first result word address, sampled on start
- count  in  ADDR_W  number of words to unload, sampled on start
- mem_rd_en  out  1  data-memory read strobe
- mem_addr  out  ADDR_W  data-memory read address
- mem_data  in  DATA_W  data-memory read data
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  unload in progress
- done  out  1  one-cycle pulse when the last byte is accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_rd_en=0, mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0.
  - Internal index=0, word register=0.
- States: IDLE, ISSUE, WAIT, SEND_HI, SEND_LO, FINISH.
- IDLE:
  - On start=1, latch base_addr and count, clear the index, set busy=1.
  - If count=0, go to FINISH. Otherwise go to ISSUE.
- ISSUE:
  - Drive mem_addr=(base+index) mod 2^ADDR_W for one cycle with mem_rd_en=1.
  - Address wrap-around is required, e.g. base=0xFE, count=4 reads FE,FF,00,01.
  - Go to WAIT.
- WAIT:
  - Count MEM_LATENCY cycles from the ISSUE cycle, then capture mem_data into the word register.
  - Go to SEND_HI.
  - mem_rd_en=0 throughout.
- SEND_HI:
  - tx_data=word[15:8], tx_valid=1.
  - Hold tx_data and tx_valid stable until tx_ready=1 is sampled, then go to SEND_LO.
- SEND_LO:
  - tx_data=word[7:0], tx_valid=1, same hold rule.
  - On acceptance, increment the index.
  - If index+1==count, go to FINISH; else go to ISSUE.
- FINISH:
  - done=1 for exactly one cycle, busy=0, tx_valid=0.
  - Return to IDLE.
- tx_valid is registered and must never drop without a handshake.
  - A byte is transferred only on a cycle with tx_valid=1 and tx_ready=1.
  - At most one transfer per cycle.
- Throughput with tx_ready tied high: per word, 1 (ISSUE) + MEM_LATENCY (WAIT) + 2 (send) cycles.
- start while busy=1 is ignored, and latched base_addr/count do not change.
- start coinciding with the FINISH cycle is also ignored. A new start is accepted only in IDLE.
- count is treated as unsigned; 0xFF words maximum.
- Asserting rst_n low mid-transfer aborts immediately to the reset values. No partial byte completes.
- mem_rd_en is never asserted outside ISSUE. The top level uses busy to hand the memory port from the core to this block.

Optional Feature:
- Macro UNLOAD_HEADER_EN.
- When defined:
  - After start with count≠0, send two header bytes before the first data word: 0xA5, then count[7:0], using the same valid/ready rules.
  - Add state HEADER with a 1-bit sub-index.
  - count=0 sends no header and goes directly to FINISH.
- When undefined: no header; the byte stream is data only.

Test Plan:
- Reset mid-transfer:
  - Stimulus: rst_n low while in SEND_HI with tx_valid=1.
  - Required: all outputs 0 within the same cycle (async); state IDLE after release.
- Basic unload, tx_ready=1, MEM_LATENCY=1:
  - Stimulus: memory[0x10..0x12]=0x1234,0xABCD,0x00FF; start with base=0x10, count=3.
  - Required: bytes 12,34,AB,CD,00,FF.
  - Required: done pulses once, 12 cycles after start; busy high throughout.
- Backpressure:
  - Stimulus: same data with tx_ready toggled randomly and held low 5 cycles on the second byte.
  - Required: tx_data stable at 0x34 and tx_valid held until accepted; same byte order; no duplicated or dropped bytes.
- Wrap and empty:
  - Stimulus: base=0xFE, count=3.
  - Required: reads FE,FF,00.
  - Stimulus: count=0.
  - Required: no mem_rd_en, no tx_valid, done pulse 1 cycle after start.
- start ignored while busy:
  - Stimulus: pulse start with base=0x40 during an unload of base=0x10, count=2.
  - Required: only addresses 0x10,0x11 are read; a single done pulse.
- UNLOAD_HEADER_EN defined:
  - Stimulus: base=0x10, count=2 with memory 0x1234,0x5678.
  - Required: A5,02,12,34,56,78.
